// File: rtl/note_chart_sequencer.sv
// Rhythm-game chart sequencer: walks a {delta, mask} chart ROM, waits delta
// game ticks per entry and fires one-cycle per-column note-launch pulses.
module note_chart_sequencer #(
    parameter int COLS    = 5,
    parameter int ADDR_W  = 8,
    parameter int DELTA_W = 8
) (
    input  logic                    Clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    pause,
    input  logic                    gameTick,
    input  logic [DELTA_W+COLS-1:0] romData,
    output logic [ADDR_W-1:0]       romAddr,
    output logic [COLS-1:0]         noteStart,
    output logic                    songActive,
    output logic                    songDone,
    output logic [15:0]             noteCount
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        WAIT_DELTA,
        EMIT,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [COLS-1:0]      mask_q, mask_d;
    logic [DELTA_W-1:0]   delta_q, delta_d;
    logic [COLS-1:0]      note_q, note_d;
    logic [15:0]          count_q, count_d;
    logic                 tick_prev_q;
    logic                 tick;
    logic [15:0]          pop;
    logic [16:0]          sum;

    assign tick = gameTick & ~tick_prev_q;

    always_comb begin
        pop = '0;
        for (int unsigned i = 0; i < COLS; i++) begin
            pop = pop + 16'(mask_q[i]);
        end
        sum = {1'b0, count_q} + {1'b0, pop};
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            mask_q      <= '0;
            delta_q     <= '0;
            note_q      <= '0;
            count_q     <= '0;
            tick_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            mask_q      <= mask_d;
            delta_q     <= delta_d;
            note_q      <= note_d;
            count_q     <= count_d;
            tick_prev_q <= gameTick;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        mask_d  = mask_q;
        delta_d = delta_q;
        count_d = count_q;
        note_d  = '0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    addr_d  = '0;
                    count_d = '0;
                    state_d = FETCH;
                end
            end
            FETCH: state_d = LOAD;
            LOAD: begin
                if (romData == '0) begin
                    state_d = DONE;
                end else begin
                    mask_d  = romData[COLS-1:0];
                    delta_d = romData[DELTA_W+COLS-1:COLS];
                    state_d = (romData[DELTA_W+COLS-1:COLS] == '0) ? EMIT : WAIT_DELTA;
                end
            end
            WAIT_DELTA: begin
                // The tick that brings the count to zero launches the note.
                if (tick && !pause) begin
                    delta_d = delta_q - DELTA_W'(1);
                    if (delta_q == DELTA_W'(1)) begin
                        state_d = EMIT;
                    end
                end
            end
            EMIT: begin
                note_d  = mask_q;
                count_d = sum[16] ? '1 : sum[15:0];
                if (addr_q == '1) begin
                    state_d = DONE;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign romAddr    = addr_q;
    assign noteStart  = note_q;
    assign noteCount  = count_q;
    assign songActive = (state_q != IDLE) && (state_q != DONE);
    assign songDone   = (state_q == DONE);

endmodule

// File: tb/tb_note_chart_sequencer.sv
// Bench for note_chart_sequencer: synchronous chart ROM model, scoreboard of
// expected note masks, table-driven chart plus hand sequences for corner cases.
module tb_note_chart_sequencer;

    logic        Clk = 1'b0;
    logic        reset;
    logic        start;
    logic        pause;
    logic        gameTick;
    logic [12:0] romData;
    logic [7:0]  romAddr;
    logic [4:0]  noteStart;
    logic        songActive;
    logic        songDone;
    logic [15:0] noteCount;

    note_chart_sequencer #(.COLS(5), .ADDR_W(8), .DELTA_W(8)) dut (
        .Clk(Clk), .reset(reset), .start(start), .pause(pause),
        .gameTick(gameTick), .romData(romData), .romAddr(romAddr),
        .noteStart(noteStart), .songActive(songActive), .songDone(songDone),
        .noteCount(noteCount)
    );

    always #5 Clk = ~Clk;

    logic [12:0] rom [0:255];
    always @(posedge Clk) romData <= rom[romAddr];

    int n_vec  = 0;
    int n_miss = 0;
    int pulses = 0;
    logic [4:0] exp_q [$];

    typedef struct {
        logic [7:0] delta;
        logic [4:0] mask;
        int         bits;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every launch pulse must match the next expected mask and be one cycle wide.
    logic [4:0] prev_note = '0;
    always @(negedge Clk) begin
        if (noteStart != '0) begin
            pulses++;
            check("pulse_width", {27'b0, prev_note}, 32'h0);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {27'b0, noteStart}, 32'h0);
            end else begin
                check("note_mask", {27'b0, noteStart}, {27'b0, exp_q.pop_front()});
            end
        end
        prev_note = noteStart;
    end

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = '0;
    endtask

    task automatic pulse_start();
        @(negedge Clk);
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit ticking);
        int cyc;
        cyc = 0;
        while (!songDone && cyc < budget) begin
            @(negedge Clk);
            if (ticking) gameTick = cyc[1];
            cyc++;
        end
        gameTick = 1'b0;
        check("done_reached", {31'b0, songDone}, 32'h1);
    endtask

    task automatic one_tick(input int high, input int low);
        gameTick = 1'b1;
        repeat (high) @(negedge Clk);
        gameTick = 1'b0;
        repeat (low) @(negedge Clk);
    endtask

    vec_t vecs [6];
    int   base;
    int   exp_total;

    initial begin
        reset = 1'b0; start = 1'b0; pause = 1'b0; gameTick = 1'b0;
        clear_rom();
        repeat (3) @(negedge Clk);
        check("rst_romAddr",    {24'b0, romAddr},    32'h0);
        check("rst_noteStart",  {27'b0, noteStart},  32'h0);
        check("rst_songActive", {31'b0, songActive}, 32'h0);
        check("rst_songDone",   {31'b0, songDone},   32'h0);
        check("rst_noteCount",  {16'b0, noteCount},  32'h0);
        reset = 1'b1;
        @(negedge Clk);

        // Latency: start at edge k, pulse visible only after edge k+3.
        rom[0] = {8'd0, 5'b00001};
        exp_q.push_back(5'b00001);
        pulse_start();
        check("lat_active", {31'b0, songActive}, 32'h1);
        @(negedge Clk); check("lat_k1", {27'b0, noteStart}, 32'h0);
        @(negedge Clk); check("lat_k2", {27'b0, noteStart}, 32'h0);
        @(negedge Clk); check("lat_k3", {27'b0, noteStart}, 32'h01);
        @(negedge Clk); check("lat_k4", {27'b0, noteStart}, 32'h0);
        wait_done(50, 1'b0);
        check("lat_count", {16'b0, noteCount}, 32'd1);
        check("lat_active_done", {31'b0, songActive}, 32'h0);

        // Delta of 3 ticks; a long-held gameTick is a single tick.
        clear_rom();
        rom[0] = {8'd3, 5'b10100};
        exp_q.push_back(5'b10100);
        base = pulses;
        pulse_start();
        repeat (4) @(negedge Clk);
        one_tick(4, 2);
        one_tick(1, 1);
        check("d3_no_early_pulse", pulses, base);
        check("d3_count_before", {16'b0, noteCount}, 32'h0);
        gameTick = 1'b1;
        @(negedge Clk); check("d3_emit_cycle", {27'b0, noteStart}, 32'h0);
        gameTick = 1'b0;
        @(negedge Clk); check("d3_pulse", {27'b0, noteStart}, 32'h14);
        check("d3_count", {16'b0, noteCount}, 32'd2);
        wait_done(50, 1'b0);

        // Paused ticks are discarded, the full delta is still needed afterwards.
        clear_rom();
        rom[0] = {8'd2, 5'b00010};
        exp_q.push_back(5'b00010);
        base = pulses;
        pulse_start();
        repeat (4) @(negedge Clk);
        pause = 1'b1;
        one_tick(2, 2);
        one_tick(2, 2);
        pause = 1'b0;
        @(negedge Clk);
        check("pause_no_pulse", pulses, base);
        one_tick(2, 4);
        check("pause_one_tick_left", pulses, base);
        check("pause_still_active", {31'b0, songActive}, 32'h1);
        one_tick(2, 4);
        check("pause_released_pulse", pulses, base + 1);
        wait_done(50, 1'b0);

        // Start ignored mid-song, then asynchronous reset abandons playback.
        clear_rom();
        rom[0] = {8'd5, 5'b11111};
        base = pulses;
        pulse_start();
        repeat (4) @(negedge Clk);
        one_tick(2, 2);
        pulse_start();
        repeat (2) @(negedge Clk);
        check("midstart_active", {31'b0, songActive}, 32'h1);
        check("midstart_addr", {24'b0, romAddr}, 32'h0);
        #2 reset = 1'b0;
        #1;
        check("arst_active", {31'b0, songActive}, 32'h0);
        check("arst_done",   {31'b0, songDone},   32'h0);
        check("arst_note",   {27'b0, noteStart},  32'h0);
        check("arst_addr",   {24'b0, romAddr},    32'h0);
        check("arst_count",  {16'b0, noteCount},  32'h0);
        @(negedge Clk);
        reset = 1'b1;
        repeat (6) one_tick(2, 2);
        check("arst_no_pulse", pulses, base);
        check("arst_idle", {31'b0, songActive}, 32'h0);

        // Table-driven chart with free-running ticks.
        vecs[0] = '{8'd0, 5'b00001, 1};
        vecs[1] = '{8'd2, 5'b10100, 2};
        vecs[2] = '{8'd0, 5'b11111, 5};
        vecs[3] = '{8'd1, 5'b01010, 2};
        vecs[4] = '{8'd4, 5'b10000, 1};
        vecs[5] = '{8'd0, 5'b00110, 2};
        clear_rom();
        exp_total = 0;
        for (int i = 0; i < 6; i++) begin
            rom[i] = {vecs[i].delta, vecs[i].mask};
            exp_q.push_back(vecs[i].mask);
            exp_total += vecs[i].bits;
        end
        base = pulses;
        pulse_start();
        wait_done(400, 1'b1);
        check("tbl_pulses", pulses, base + 6);
        check("tbl_count", {16'b0, noteCount}, exp_total);
        check("tbl_addr", {24'b0, romAddr}, 32'd6);

        // Full 256-entry chart: stops after address 255 without wrapping.
        for (int i = 0; i < 256; i++) begin
            rom[i] = {8'd0, 5'b11111};
            exp_q.push_back(5'b11111);
        end
        base = pulses;
        pulse_start();
        wait_done(1300, 1'b0);
        check("full_count", {16'b0, noteCount}, 32'd1280);
        check("full_addr", {24'b0, romAddr}, 32'd255);
        repeat (8) @(negedge Clk);
        check("full_pulses", pulses, base + 256);
        check("full_stays_done", {31'b0, songDone}, 32'h1);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/note_chart_sequencer.md
NOTE_CHART_SEQUENCER -- requirements
Module: note_chart_sequencer

Interface
REQ-001 SHALL have parameter COLS, default 5: number of note columns (one downstream timer column per bit).
REQ-002 SHALL have parameter ADDR_W, default 8: chart ROM address width.
REQ-003 SHALL have parameter DELTA_W, default 8: delta-tick field width.
REQ-004 SHALL have port Clk, input, 1: single system clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1: reset, asynchronous, active-low (0 = reset).
REQ-006 SHALL have port start, input, 1: begin playback from chart address 0.
REQ-007 SHALL have port pause, input, 1: freeze song time while high.
REQ-008 SHALL have port gameTick, input, 1: game-time level signal; each rising edge is one tick.
REQ-009 SHALL have port romData, input, DELTA_W+COLS: chart entry {delta[DELTA_W-1:0], mask[COLS-1:0]}; valid one cycle after romAddr.
REQ-010 SHALL have port romAddr, output, ADDR_W: chart ROM address, registered.
REQ-011 SHALL have port noteStart, output, COLS: per-column one-cycle note-launch pulses to the timer columns.
REQ-012 SHALL have port songActive, output, 1: high in any state other than IDLE and DONE.
REQ-013 SHALL have port songDone, output, 1: high in DONE.
REQ-014 SHALL have port noteCount, output, 16: total notes launched this song.

Function
REQ-015 SHALL derive tick = gameTick AND NOT gameTickPrev, where gameTickPrev is a register.
REQ-016 SHALL implement the states IDLE, FETCH, LOAD, WAIT_DELTA, EMIT and DONE.
REQ-017 IDLE/DONE: start=1 SHALL set romAddr to 0, clear noteCount and go to FETCH.
REQ-018 FETCH SHALL go to LOAD unconditionally; romAddr is stable during FETCH.
REQ-019 LOAD entry of all zeros SHALL be end-of-chart and go to DONE.
REQ-020 LOAD with a nonzero entry SHALL latch mask, load deltaCnt from delta, and go to EMIT if delta=0, else WAIT_DELTA.
REQ-021 WAIT_DELTA with tick=1 and pause=0 SHALL decrement deltaCnt; deltaCnt=0 SHALL go to EMIT.
REQ-022 Ticks arriving while pause=1 SHALL be discarded, not deferred.
REQ-023 noteStart SHALL equal the latched mask in EMIT and be 0 in every other state.
REQ-024 Every noteStart pulse SHALL be exactly one Clk cycle wide.
REQ-025 EMIT SHALL add popcount(mask) to noteCount, saturating at 16'hFFFF.
REQ-026 EMIT with romAddr all-ones SHALL go to DONE (address does not wrap).
REQ-027 EMIT with romAddr not all-ones SHALL increment romAddr and go to FETCH.
REQ-028 start in FETCH, LOAD, WAIT_DELTA or EMIT SHALL be ignored (no restart mid-song).
REQ-029 pause SHALL affect only tick consumption; FETCH, LOAD and EMIT proceed while paused.
REQ-030 Latency: start sampled at edge k with entry 0 delta=0 SHALL make noteStart high for the cycle after edge k+3.
REQ-031 Delta semantics: delta is ticks counted from the previous entry's EMIT; delta=0 launches with no tick wait.
REQ-032 A tick coinciding with FETCH, LOAD or EMIT SHALL be discarded.

Reset
REQ-033 reset=0 SHALL immediately force IDLE, romAddr=0, noteStart=0, songActive=0, songDone=0, noteCount=0, deltaCnt=0, latched mask=0 and gameTickPrev=0, regardless of Clk.
REQ-034 reset asserted mid-song SHALL abandon playback, with no noteStart pulse after reset release until a new start.

Verification
REQ-035 Chart {addr0: delta 0 mask 5'b00001, addr1: 0}; start pulse at edge k -> noteStart=00001 for one cycle after edge k+3; songDone=1 afterwards; noteCount=1.
REQ-036 Entry delta=3, mask 10100 -> no pulse before the 3rd gameTick rising edge; pulse after the 3rd edge; noteCount+=2; a gameTick held high several cycles counts as one tick.
REQ-037 pause=1 during WAIT_DELTA with 2 ticks applied -> deltaCnt unchanged; release pause -> the full remaining delta is still required.
REQ-038 Chart with all 256 entries nonzero, mask 11111 -> DONE after address 255 with no wrap; noteCount=1280.
REQ-039 reset=0 asynchronously in WAIT_DELTA -> all outputs 0 before the next Clk edge; start during WAIT_DELTA -> no effect.
